// File: rtl/serial_adder_32bit.sv
// Digit-serial adder: A + B + Cin computed DIGIT bits per clock through one carry-lookahead slice.
// Define SERIAL_ADDER_OVF_EN to add the registered signed Overflow output.
module serial_adder_32bit #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             Overflow
`endif
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] res_sh_q;
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;

  logic [DIGIT-1:0] g;
  logic [DIGIT-1:0] p;
  logic [DIGIT-1:0] sum_dig;
  logic [DIGIT:0]   c;
  logic [WIDTH-1:0] res_sh_d;
  logic             carry_d;
  logic             last_digit;

  assign g = a_sh_q[DIGIT-1:0] & b_sh_q[DIGIT-1:0];
  assign p = a_sh_q[DIGIT-1:0] ^ b_sh_q[DIGIT-1:0];

  // Each carry is the flat OR of generate terms gated by the propagate run above them,
  // so no carry waits on the one below it.
  always_comb begin
    logic acc;
    logic prop;
    c[0] = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      acc  = g[i];
      prop = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc  = acc | (g[j] & prop);
        prop = prop & p[j];
      end
      c[i+1] = acc | (carry_q & prop);
    end
  end

  assign sum_dig    = p ^ c[DIGIT-1:0];
  assign carry_d    = c[DIGIT];
  assign res_sh_d   = {sum_dig, res_sh_q[WIDTH-1:DIGIT]};
  assign last_digit = (cnt_q == CW'(NDIG - 1));

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;
  logic ovf_d;
  assign ovf_d    = c[DIGIT] ^ c[DIGIT-1];
  assign Overflow = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sh_q   <= A;
            b_sh_q   <= B;
            carry_q  <= Cin;
            res_sh_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh_q   <= a_sh_q >> DIGIT;
          b_sh_q   <= b_sh_q >> DIGIT;
          res_sh_q <= res_sh_d;
          carry_q  <= carry_d;
          cnt_q    <= cnt_q + 1'b1;
          if (last_digit) begin
            result_q <= res_sh_d;
            cout_q   <= carry_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= ovf_d;
`endif
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign Result = result_q;
  assign Cout   = cout_q;

endmodule

// File: doc/serial_adder_32bit.md
Name: serial_adder_32bit

Overview:
- Multi-cycle 32-bit adder. It computes A + B + Cin one 4-bit digit per clock, using a single 4-bit carry-lookahead slice and a registered carry between digits.
- It is the addition counterpart to the combinational 32-bit subtractor.
- It also gives the datapath a low-area add path with a start/done handshake for the sequential ALU.
- Subtraction through this block is done by driving B inverted and Cin = 1.

Parameters:
WIDTH, 32, operand and result width; must be a multiple of DIGIT
DIGIT, 4, bits added per cycle (width of the CLA slice)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only in IDLE
A  input  WIDTH  operand A; sampled on the accepting edge
B  input  WIDTH  operand B; sampled on the accepting edge
Cin  input  1  carry-in; sampled on the accepting edge
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when Result/Cout become valid
Result  output  WIDTH  sum, registered; held until the next completion
Cout  output  1  final carry-out, registered; held with Result

Behaviour:
- Reset (rst_n low at a rising edge): all of the following are cleared.
  - State -> IDLE.
  - busy = 0, done = 0, Result = 0, Cout = 0.
  - Digit counter, operand shift registers and carry register = 0.
  - Reset mid-RUN aborts the add with no done pulse.
- IDLE:
  - On the edge where start = 1: latch A, B into shift registers, latch Cin into the carry register, set counter = 0, go to RUN (busy = 1 from that edge).
  - start = 0: remain in IDLE.
- RUN, one digit per edge:
  - sum = A_sh[DIGIT-1:0] + B_sh[DIGIT-1:0] + carry.
  - Shift the low DIGIT bits of sum into the top of the result shift register.
  - carry <= digit carry-out.
  - Shift A_sh and B_sh right by DIGIT.
  - counter increments.
  - On the edge processing digit WIDTH/DIGIT-1 (counter = 7 by default): load Result from the completed shift value, load Cout from the final carry, busy -> 0, done -> 1, go to DONE.
- DONE:
  - done stays high for exactly this one cycle.
  - Next edge: done -> 0, go to IDLE unconditionally.
- Latency: start accepted at edge N gives done high during the cycle after edge N+8 (N+WIDTH/DIGIT in general). Throughput is one add per 10 cycles.
- start asserted in RUN or DONE is ignored, not queued. Inputs A/B/Cin changing during RUN have no effect.
- Result/Cout are not modified during RUN; the previous result stays visible until the completing edge.
- Arithmetic is modulo 2^WIDTH; the carry out of the MSB goes only to Cout.
- Counter is log2(WIDTH/DIGIT) bits and never wraps within a legal run.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port Overflow (output, 1 bit, registered).
  - Loaded on the completing edge with signed overflow = carry into MSB XOR carry out of MSB.
  - Reset value 0; held with Result.
- Undefined: no Overflow port and no related logic. All other behaviour is identical.

Test Plan:
- Basic add, normal result: reset 2 cycles; A = 110000, B = 120000, Cin = 0, start 1 cycle.
  - Required: busy high 8 cycles; done pulses once; Result = 0x00038270 (230000), Cout = 0.
- Subtract via inversion: A = 110000, B = ~120000, Cin = 1.
  - Required: Result = 0xFFFFD8F0 (-10000), Cout = 0. Matches the combinational subtractor for the same operands.
- Carry chain, full wrap: A = 0xFFFFFFFF, B = 0x00000001, Cin = 0.
  - Required: Result = 0x00000000, Cout = 1.
- Signed overflow (with SERIAL_ADDER_OVF_EN): A = 0x7FFFFFFF, B = 0, Cin = 1.
  - Required: Result = 0x80000000, Cout = 0, Overflow = 1.
  - Then A = 5, B = 3: Result = 8, Overflow = 0.
- Start ignored while busy: start an add (A = 1, B = 2); reassert start with A = 100 at cycle 3 and again in the DONE cycle.
  - Required: single done; Result = 3.
  - A new start in IDLE afterwards completes normally.
- Reset mid-operation: start A = 0xFFFFFFFF, B = 1; drop rst_n at RUN cycle 4.
  - Required: next cycle busy = 0, done = 0, Result = 0, Cout = 0; no done pulse follows.
  - A subsequent add of 7 + 8 gives 15.
